dense_l3_wloader: RTL and testbench

Write-side loader for the dense layer-3 weight memory. Accepts a valid/ready stream of 32-bit weights and writes them into the eight dual-port weight banks. Words land in exactly the layout the layer-3 reader fetches: one read at `addr_base = 2*r` returns 16 words per row. The loader sits between the host/DMA weight stream and the bank write ports, and reports completion and a running checksum.

---
 rtl/dense_l3_pkg.sv | 17 +
 rtl/dense_l3_wloader_if.sv | 12 +
 rtl/dense_l3_wloader.sv | 106 ++++++++++
 tb/tb_dense_l3_wloader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dense_l3_pkg.sv
// Shared constants and state type for the dense layer-3 weight memory
// (loader, reader and memory wrapper).
package dense_l3_pkg;

    localparam int NUM_BANKS     = 8;
    localparam int WORDS_PER_ROW = 2 * NUM_BANKS;
    localparam int DATA_W        = 32;
    localparam int ADDR_W        = 8;
    localparam int J_W           = $clog2(WORDS_PER_ROW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wl_state_t;

endpackage

// File: rtl/dense_l3_wloader_if.sv
// Valid/ready weight stream feeding the layer-3 loader.
interface dense_l3_wloader_if
    import dense_l3_pkg::*;
;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/dense_l3_wloader.sv
// Streams 32-bit weights into the eight layer-3 banks in reader layout,
// with a one-cycle registered write port and a running checksum.
module dense_l3_wloader
    import dense_l3_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-2:0]    row_base,
    input  logic [ADDR_W-1:0]    row_count,
    dense_l3_wloader_if.slave    s,
    output logic [NUM_BANKS-1:0] mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_din,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          checksum
);

    wl_state_t         state_q;
    wl_state_t         state_d;
    logic [J_W-1:0]    j_q;
    logic [ADDR_W-1:0] r_q;
    logic [ADDR_W-2:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic              accept;
    logic              last_word;
    logic              start_ok;
    logic [ADDR_W-1:0] row_sum;

    assign s.s_ready = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign accept    = s.s_valid && (state_q == LOAD);
    assign start_ok  = start && (state_q == IDLE);
    assign last_word = accept
                     && (j_q == J_W'(WORDS_PER_ROW - 1))
                     && (r_q == count_q - 1'b1);

    // Bank address is 2*(base+r); the top bit of base+r falls off on wrap.
    assign row_sum = ADDR_W'(base_q) + r_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (row_count != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (last_word) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            j_q      <= '0;
            r_q      <= '0;
            base_q   <= '0;
            count_q  <= '0;
            checksum <= '0;
        end else if (start_ok) begin
            j_q      <= '0;
            r_q      <= '0;
            base_q   <= row_base;
            count_q  <= row_count;
            checksum <= '0;
        end else if (accept) begin
            j_q      <= j_q + 1'b1;
            checksum <= checksum + s.s_data;
            if (j_q == J_W'(WORDS_PER_ROW - 1)) begin
                r_q <= r_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we   <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            mem_we <= '0;
            if (accept) begin
                mem_we   <= NUM_BANKS'(1) << j_q[J_W-1:1];
                mem_addr <= {row_sum[ADDR_W-2:0], j_q[0]};
                mem_din  <= s.s_data;
            end
        end
    end

endmodule

// File: tb/tb_dense_l3_wloader.sv
// Directed table-driven bench for the layer-3 weight loader.
module tb_dense_l3_wloader;
    import dense_l3_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [ADDR_W-2:0]    row_base;
    logic [ADDR_W-1:0]    row_count;
    logic [NUM_BANKS-1:0] mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_din;
    logic                 busy;
    logic                 done;
    logic [31:0]          checksum;

    int n_tests = 0;
    int n_fail  = 0;

    dense_l3_wloader_if sif ();

    dense_l3_wloader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_base  (row_base),
        .row_count (row_count),
        .s         (sif.slave),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  base;
        logic [7:0]  count;
        bit          toggle;
        bit          poke;
        logic [31:0] dbase;
        logic [31:0] cs;
        int          writes;
        int          done_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input vec_t v);
        int          cyc;
        int          nw;
        int          sent;
        bit          got_done;
        bit          ready_seen;
        bit          vld;
        int          row;
        int          jj;
        logic [7:0]  exp_we;
        logic [7:0]  exp_addr;
        start     = 1'b1;
        row_base  = v.base;
        row_count = v.count;
        tick();
        start      = 1'b0;
        cyc        = 0;
        nw         = 0;
        sent       = 0;
        got_done   = 0;
        ready_seen = 0;
        while (!got_done && cyc < 300) begin
            if (mem_we != '0) begin
                row      = nw / WORDS_PER_ROW;
                jj       = nw % WORDS_PER_ROW;
                exp_we   = 8'd1 << (jj >> 1);
                exp_addr = 8'((int'(v.base) + row) * 2 + (jj & 1));
                if (nw < v.writes) begin
                    check("wr_bank", 32'(mem_we), 32'(exp_we));
                    check("wr_addr", 32'(mem_addr), 32'(exp_addr));
                    check("wr_data", mem_din, v.dbase + 32'(nw));
                end else begin
                    check("extra_write", 32'(nw), 32'(v.writes - 1));
                end
                nw++;
            end
            if (sif.s_ready) ready_seen = 1;
            if (done) begin
                got_done = 1;
                check("done_cycle", 32'(cyc), 32'(v.done_cyc));
            end else begin
                vld         = v.toggle ? (cyc % 2 == 0) : 1'b1;
                sif.s_valid = vld;
                sif.s_data  = v.dbase + 32'(sent);
                if (vld && sif.s_ready) sent++;
                if (v.poke) begin
                    start    = (cyc == 4);
                    row_base = (cyc == 4) ? 7'd50 : v.base;
                end
                tick();
                cyc++;
            end
        end
        if (!got_done) check("done_timeout", 32'(cyc), 32'(v.done_cyc));
        sif.s_valid = 1'b0;
        start       = 1'b0;
        check("write_count", 32'(nw), 32'(v.writes));
        check("checksum", checksum, v.cs);
        check("busy_at_done", 32'(busy), 32'd1);
        check("ready_seen", 32'(ready_seen), 32'(v.count != 0));
        tick();
        check("busy_after", 32'(busy), 32'd0);
        check("done_after", 32'(done), 32'd0);
        check("we_after", 32'(mem_we), 32'd0);
        check("ready_after", 32'(sif.s_ready), 32'd0);
        check("checksum_hold", checksum, v.cs);
    endtask

    initial begin
        vec_t rv;
        int   nw;
        int   guard;
        vecs[0] = '{7'd0,   8'd1, 1'b0, 1'b0, 32'h100, 32'h1078, 16, 16};
        vecs[1] = '{7'd0,   8'd1, 1'b1, 1'b0, 32'h100, 32'h1078, 16, 31};
        vecs[2] = '{7'd5,   8'd0, 1'b0, 1'b0, 32'h100, 32'h0,    0,  0};
        vecs[3] = '{7'd127, 8'd2, 1'b0, 1'b0, 32'h200, 32'h41F0, 32, 32};
        vecs[4] = '{7'd10,  8'd1, 1'b0, 1'b1, 32'h300, 32'h3078, 16, 16};

        rst         = 1'b1;
        start       = 1'b0;
        row_base    = '0;
        row_count   = '0;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        tick();
        tick();
        check("rst_ready", 32'(sif.s_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_din", mem_din, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_checksum", checksum, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_load(vecs[i]);
        end

        // Reset in the middle of a load, right after the fifth write shows.
        start     = 1'b1;
        row_base  = 7'd0;
        row_count = 8'd1;
        tick();
        start       = 1'b0;
        nw          = 0;
        guard       = 0;
        sif.s_valid = 1'b1;
        sif.s_data  = 32'h500;
        while (nw < 5 && guard < 50) begin
            tick();
            guard++;
            if (mem_we != '0) nw++;
            sif.s_data = 32'h500 + 32'(guard);
        end
        check("partial_writes", 32'(nw), 32'd5);
        rst = 1'b1;
        tick();
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_ready", 32'(sif.s_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_checksum", checksum, 32'd0);
        rst         = 1'b0;
        sif.s_valid = 1'b0;
        tick();
        rv = '{7'd3, 8'd1, 1'b0, 1'b0, 32'h400, 32'h4078, 16, 16};
        run_load(rv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
